mem_bus_arbiter: RTL and testbench
==================================

# mem_bus_arbiter

Parametrised N-port arbiter merging several valid/ready requesters onto one valid/ready memory bus. It supports fixed-priority or round-robin grant, holds each grant until its transaction completes, and optionally times out a hung slave with an error response. It sits between the CPU's instruction/data ports plus any extra bus masters (e.g. DMA) and the SoC memory/peripheral interconnect.

## Interface
- NUM_PORTS, 2: requester count, 2..8.
- ADDR_W, 32: address width.
- DATA_W, 32: data width; multiple of 8.
- PRIO_MODE, 0: 0 = fixed priority (port 0 highest), 1 = round-robin.
- TIMEOUT_CYCLES, 0: 0 disables the timeout; otherwise the maximum number of BUSY cycles before forced completion. Legal range 0..65535.
- clk  in  1  clock.
- resetn  in  1  reset, synchronous, active-low.
- req_valid  in  NUM_PORTS  per-port request.
- req_instr  in  NUM_PORTS  per-port instruction-fetch flag.
- req_addr  in  NUM_PORTS*ADDR_W  packed addresses; port i occupies bits [i*ADDR_W +: ADDR_W].
- req_wdata  in  NUM_PORTS*DATA_W  packed write data.
- req_wstrb  in  NUM_PORTS*DATA_W/8  packed byte strobes; all zero means a read.
- req_ready  out  NUM_PORTS  per-port completion strobe, at most one bit high.
- req_error  out  NUM_PORTS  per-port timeout flag, qualified by req_ready.
- req_rdata  out  DATA_W  read data, broadcast to all ports.
- mem_valid  out  1  bus request.
- mem_instr  out  1  bus instruction flag.
- mem_addr  out  ADDR_W  bus address.
- mem_wdata  out  DATA_W  bus write data.
- mem_wstrb  out  DATA_W/8  bus byte strobes.
- mem_ready  in  1  slave completion.
- mem_rdata  in  DATA_W  slave read data.
- grant_id  out  $clog2(NUM_PORTS)  port currently driving the bus; 0 when idle.
- busy  out  1  high in the BUSY state.

## Operation
- Protocol: each requester holds valid and all its fields stable until req_ready. A transaction completes in the cycle where mem_valid & mem_ready.
- States: IDLE and BUSY. Registered state: owner, rr_last, tcnt.
- IDLE, no req_valid bits set:
  - mem_valid=0; all mem fields 0; req_ready=0.
- IDLE, any req_valid bit set:
  - Winner w is chosen combinationally.
  - Fixed mode: w = lowest set index.
  - RR mode: w = first set index searching from rr_last+1, wrapping modulo NUM_PORTS.
  - The bus is driven from port w and mem_valid=1.
  - If mem_ready: req_ready[w]=1 and the state stays IDLE.
  - Else: BUSY, owner<=w, tcnt<=1.
- BUSY:
  - The bus is driven from owner with mem_valid=1, independent of req_valid; the arbiter never re-arbitrates.
  - mem_ready: req_ready[owner]=1, then IDLE.
  - Else if TIMEOUT_CYCLES!=0 and tcnt==TIMEOUT_CYCLES: req_ready[owner]=1, req_error[owner]=1, req_rdata=all ones, mem_valid=0, then IDLE. A late mem_ready is ignored.
  - Else: tcnt increments. tcnt is 16 bits and saturates.
- rr_last <= the completing port on every completion, including error completions. It is unused in fixed mode.
- req_rdata = mem_rdata except on an error completion.
- mem_wstrb = wstrb of the granted port. Reads pass zero strobes.
- Reset (resetn low at a clock edge), taking effect at that edge:
  - state=IDLE, owner=0, tcnt=0, rr_last=NUM_PORTS-1, so port 0 is first after reset.
  - A BUSY transaction is abandoned without a req_ready.
  - While resetn is low, mem_valid=0, req_ready=0, req_error=0, busy=0, grant_id=0.

## Timing
- Zero-cycle arbitration. These paths are combinational:
  - req_valid → mem_valid/mem_addr
  - mem_ready → req_ready
- Single-cycle slave: one transaction per cycle. Under RR with all ports requesting, the grant rotates every cycle.
- Wait-state slave with k wait cycles: the owner's req_ready arrives k cycles after the first mem_valid cycle. The next grant can occur in the cycle after completion.
- Timeout: error completion occurs TIMEOUT_CYCLES cycles after the first mem_valid cycle.
- A requester deasserting valid during BUSY is a protocol violation. The arbiter keeps driving the bus until completion.

## Structure
- Package mem_bus_pkg holds:
  - state enum {IDLE, BUSY}
  - PRIO_FIXED=0, PRIO_RR=1
  - TCNT_W=16
  - ERR_RDATA (all ones)
- One sub-module, rr_pick: combinational rotating find-first. Inputs are the req vector and the start index; outputs are the winner index and an any flag. Fixed mode instantiates it with start=0.

## Test plan
- Fixed mode, 2 ports, both requesting, slave with 0 waits: port 0 is granted every cycle and port 1 is starved until port 0 drops. Check grant_id=0.
- RR mode, 3 ports, all requesting continuously, 0 waits: grant sequence 0,1,2,0,1,2; one req_ready per cycle.
- RR mode, slave with 3 waits, port 1 granted, port 0 raises valid mid-transaction: mem_addr stays at port 1's address for 4 cycles, req_ready[1] fires in cycle 4, then port 0 is granted.
- TIMEOUT_CYCLES=8, slave never ready: at the 8th cycle req_ready=1, req_error=1, req_rdata=0xFFFFFFFF, then mem_valid=0.
- Write from port 2 with wstrb 4'b0110 and wdata 0xA5A5_5A5A at addr 0x100: the bus shows identical fields and mem_instr=0.
- resetn pulsed low while BUSY on port 1: no req_ready; the next cycle is IDLE; with all ports requesting after reset, port 0 is granted first.

Source files
------------

// File: rtl/mem_bus_pkg.sv
// Shared types and constants for the memory bus arbiter.
package mem_bus_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_e;

  localparam int unsigned PRIO_FIXED = 0;
  localparam int unsigned PRIO_RR    = 1;
  localparam int unsigned TCNT_W     = 16;

  // Wide enough for any practical DATA_W; users truncate to their width.
  localparam int unsigned ERR_RDATA_MAX_W = 1024;
  localparam logic [ERR_RDATA_MAX_W-1:0] ERR_RDATA = '1;

endpackage

// File: rtl/mem_bus_arbiter_rr_pick.sv
// Rotating find-first: lowest set bit of req searching upward from start, wrapping.
module rr_pick #(
  parameter int unsigned N     = 2,
  parameter int unsigned IDX_W = 1
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] start,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  logic [N-1:0] rot;

  always_comb begin
    rot = N'({req, req} >> start);
    idx = '0;
    any = |req;
    // Descending scan so the smallest offset from start wins.
    for (int j = N - 1; j >= 0; j--) begin
      if (rot[j]) begin
        idx = IDX_W'((int'(start) + j) % int'(N));
      end
    end
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// N-port valid/ready arbiter onto a single memory bus; fixed or round-robin
// grant, grant held until completion, optional hung-slave timeout.
module mem_bus_arbiter
  import mem_bus_pkg::*;
#(
  parameter int unsigned NUM_PORTS      = 2,
  parameter int unsigned ADDR_W         = 32,
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned PRIO_MODE      = 0,
  parameter int unsigned TIMEOUT_CYCLES = 0
) (
  input  logic                            clk,
  input  logic                            resetn,
  input  logic [NUM_PORTS-1:0]            req_valid,
  input  logic [NUM_PORTS-1:0]            req_instr,
  input  logic [NUM_PORTS*ADDR_W-1:0]     req_addr,
  input  logic [NUM_PORTS*DATA_W-1:0]     req_wdata,
  input  logic [NUM_PORTS*DATA_W/8-1:0]   req_wstrb,
  output logic [NUM_PORTS-1:0]            req_ready,
  output logic [NUM_PORTS-1:0]            req_error,
  output logic [DATA_W-1:0]               req_rdata,
  output logic                            mem_valid,
  output logic                            mem_instr,
  output logic [ADDR_W-1:0]               mem_addr,
  output logic [DATA_W-1:0]               mem_wdata,
  output logic [DATA_W/8-1:0]             mem_wstrb,
  input  logic                            mem_ready,
  input  logic [DATA_W-1:0]               mem_rdata,
  output logic [$clog2(NUM_PORTS)-1:0]    grant_id,
  output logic                            busy
);

  localparam int unsigned IDX_W  = $clog2(NUM_PORTS);
  localparam int unsigned STRB_W = DATA_W / 8;

  arb_state_e        state;
  logic [IDX_W-1:0]  owner;
  logic [IDX_W-1:0]  rr_last;
  logic [TCNT_W-1:0] tcnt;

  logic [IDX_W-1:0]  rr_start;
  logic [IDX_W-1:0]  pick_start;
  logic [IDX_W-1:0]  win;
  logic              any_req;
  logic              timeout_hit;

  logic [IDX_W-1:0]  sel;
  logic              drive;
  logic              done;
  logic              err_done;

  always_comb begin
    rr_start    = (rr_last == IDX_W'(NUM_PORTS - 1)) ? '0 : rr_last + IDX_W'(1);
    pick_start  = (PRIO_MODE == PRIO_RR) ? rr_start : '0;
    timeout_hit = (TIMEOUT_CYCLES != 0) && (tcnt == TCNT_W'(TIMEOUT_CYCLES));
  end

  rr_pick #(
    .N     (NUM_PORTS),
    .IDX_W (IDX_W)
  ) u_pick (
    .req   (req_valid),
    .start (pick_start),
    .idx   (win),
    .any   (any_req)
  );

  // Bus mux, completion and response; everything forced quiet while in reset.
  always_comb begin
    sel       = win;
    drive     = 1'b0;
    done      = 1'b0;
    err_done  = 1'b0;
    req_ready = '0;
    req_error = '0;
    req_rdata = mem_rdata;
    mem_valid = 1'b0;
    mem_instr = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_wstrb = '0;
    grant_id  = '0;
    busy      = 1'b0;

    if (resetn) begin
      if (state == BUSY) begin
        sel      = owner;
        busy     = 1'b1;
        grant_id = owner;
        if (mem_ready) begin
          drive = 1'b1;
          done  = 1'b1;
        end else if (timeout_hit) begin
          err_done = 1'b1;
          done     = 1'b1;
        end else begin
          drive = 1'b1;
        end
      end else if (any_req) begin
        sel      = win;
        grant_id = win;
        drive    = 1'b1;
        done     = mem_ready;
      end

      for (int i = 0; i < NUM_PORTS; i++) begin
        if (sel == IDX_W'(i)) begin
          if (drive) begin
            mem_instr = req_instr[i];
            mem_addr  = req_addr[i*ADDR_W +: ADDR_W];
            mem_wdata = req_wdata[i*DATA_W +: DATA_W];
            mem_wstrb = req_wstrb[i*STRB_W +: STRB_W];
          end
          req_ready[i] = done;
          req_error[i] = err_done;
        end
      end

      mem_valid = drive;
      if (err_done) begin
        req_rdata = DATA_W'(ERR_RDATA);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state   <= IDLE;
      owner   <= '0;
      tcnt    <= '0;
      rr_last <= IDX_W'(NUM_PORTS - 1);
    end else begin
      if (done) begin
        rr_last <= sel;
      end
      case (state)
        IDLE: begin
          if (any_req && !mem_ready) begin
            state <= BUSY;
            owner <= win;
            tcnt  <= TCNT_W'(1);
          end
        end
        BUSY: begin
          if (done) begin
            state <= IDLE;
            tcnt  <= '0;
          end else if (tcnt != '1) begin
            tcnt <= tcnt + TCNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: a 3-port round-robin instance with timeout and a
// 2-port fixed-priority instance, completions checked against a scoreboard.
module tb_mem_bus_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic resetn;

  // Round-robin instance: 3 ports, timeout 8
  logic [2:0]  r_valid, r_instr, r_ready, r_error;
  logic [95:0] r_addr, r_wdata;
  logic [11:0] r_wstrb;
  logic [31:0] r_rdata;
  logic        m_valid, m_instr, m_ready;
  logic [31:0] m_addr, m_wdata, m_rdata;
  logic [3:0]  m_wstrb;
  logic [1:0]  r_gid;
  logic        r_busy;

  // Fixed-priority instance: 2 ports, no timeout
  logic [1:0]  f_valid, f_instr, f_ready, f_error;
  logic [63:0] f_addr, f_wdata;
  logic [7:0]  f_wstrb;
  logic [31:0] f_rdata;
  logic        fm_valid, fm_instr, fm_ready;
  logic [31:0] fm_addr, fm_wdata, fm_rdata;
  logic [3:0]  fm_wstrb;
  logic [0:0]  f_gid;
  logic        f_busy;

  mem_bus_arbiter #(
    .NUM_PORTS(3), .ADDR_W(32), .DATA_W(32), .PRIO_MODE(1), .TIMEOUT_CYCLES(8)
  ) u_rr (
    .clk(clk), .resetn(resetn),
    .req_valid(r_valid), .req_instr(r_instr), .req_addr(r_addr),
    .req_wdata(r_wdata), .req_wstrb(r_wstrb),
    .req_ready(r_ready), .req_error(r_error), .req_rdata(r_rdata),
    .mem_valid(m_valid), .mem_instr(m_instr), .mem_addr(m_addr),
    .mem_wdata(m_wdata), .mem_wstrb(m_wstrb),
    .mem_ready(m_ready), .mem_rdata(m_rdata),
    .grant_id(r_gid), .busy(r_busy)
  );

  mem_bus_arbiter #(
    .NUM_PORTS(2), .ADDR_W(32), .DATA_W(32), .PRIO_MODE(0), .TIMEOUT_CYCLES(0)
  ) u_fix (
    .clk(clk), .resetn(resetn),
    .req_valid(f_valid), .req_instr(f_instr), .req_addr(f_addr),
    .req_wdata(f_wdata), .req_wstrb(f_wstrb),
    .req_ready(f_ready), .req_error(f_error), .req_rdata(f_rdata),
    .mem_valid(fm_valid), .mem_instr(fm_instr), .mem_addr(fm_addr),
    .mem_wdata(fm_wdata), .mem_wstrb(fm_wstrb),
    .mem_ready(fm_ready), .mem_rdata(fm_rdata),
    .grant_id(f_gid), .busy(f_busy)
  );

  // Slave models: rr slave has programmable wait states or hangs forever
  int waits;
  bit never;
  int wcnt;

  always_comb m_ready = !never && (wcnt == waits);
  assign m_rdata  = m_addr ^ 32'hDEAD_0000;
  assign fm_ready = 1'b1;
  assign fm_rdata = fm_addr ^ 32'hBEEF_0000;

  always @(posedge clk) begin
    if (!resetn || !m_valid || m_ready) wcnt <= 0;
    else wcnt <= wcnt + 1;
  end

  // Checking
  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  typedef struct {
    int          port;
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t rq[$];
  exp_t fq[$];

  task automatic rpush(input int p, input logic [31:0] rd, input logic e);
    exp_t x;
    x.port = p; x.rdata = rd; x.err = e;
    rq.push_back(x);
  endtask

  task automatic fpush(input int p, input logic [31:0] rd, input logic e);
    exp_t x;
    x.port = p; x.rdata = rd; x.err = e;
    fq.push_back(x);
  endtask

  function automatic logic [31:0] raddr(input int p);
    return 32'h1000 + 32'(p) * 32'h10;
  endfunction

  // Scoreboard monitors: every completion strobe pops one expectation
  always @(negedge clk) begin
    exp_t e;
    int p;
    if (r_ready != '0) begin
      p = 0;
      for (int i = 0; i < 3; i++) if (r_ready[i]) p = i;
      check("rr_onehot", 64'($countones(r_ready)), 1);
      if (rq.size() == 0) begin
        check("rr_unexpected_ready", 64'(r_ready), 0);
      end else begin
        e = rq.pop_front();
        check("rr_port", 64'(p), 64'(e.port));
        check("rr_rdata", r_rdata, e.rdata);
        check("rr_errvec", 64'(r_error), e.err ? 64'(1 << p) : 64'd0);
      end
    end else if (r_error != '0) begin
      check("rr_err_without_ready", 64'(r_error), 0);
    end
  end

  always @(negedge clk) begin
    exp_t e;
    int p;
    if (f_ready != '0) begin
      p = 0;
      for (int i = 0; i < 2; i++) if (f_ready[i]) p = i;
      check("fix_onehot", 64'($countones(f_ready)), 1);
      if (fq.size() == 0) begin
        check("fix_unexpected_ready", 64'(f_ready), 0);
      end else begin
        e = fq.pop_front();
        check("fix_port", 64'(p), 64'(e.port));
        check("fix_rdata", f_rdata, e.rdata);
        check("fix_err", 64'(f_error), 0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    resetn = 1'b0;
    waits = 0; never = 1'b0;
    r_instr = '0; r_wdata = '0; r_wstrb = '0;
    f_instr = '0; f_wdata = '0; f_wstrb = '0;
    for (int p = 0; p < 3; p++) r_addr[p*32 +: 32] = raddr(p);
    f_addr = {32'h0000_0204, 32'h0000_0200};

    // Reset with requests pending: bus must stay quiet
    r_valid = 3'b111; f_valid = 2'b11;
    @(posedge clk); #1;
    @(negedge clk);
    check("rst_mvalid", 64'(m_valid), 0);
    check("rst_ready", 64'(r_ready), 0);
    check("rst_busy", 64'(r_busy), 0);
    check("rst_gid", 64'(r_gid), 0);
    check("rst_fix_mvalid", 64'(fm_valid), 0);
    check("rst_fix_ready", 64'(f_ready), 0);
    @(posedge clk); #1;
    r_valid = '0; f_valid = '0;
    @(posedge clk); #1;
    resetn = 1'b1;

    // Fixed priority: port 0 wins every cycle, port 1 starved
    f_valid = 2'b11;
    for (int i = 0; i < 4; i++) begin
      fpush(0, 32'h200 ^ 32'hBEEF_0000, 1'b0);
      @(negedge clk);
      check("fix_gid0", 64'(f_gid), 0);
      check("fix_addr0", fm_addr, 32'h200);
      @(posedge clk); #1;
    end
    f_valid = 2'b10;
    fpush(1, 32'h204 ^ 32'hBEEF_0000, 1'b0);
    @(negedge clk);
    check("fix_gid1", 64'(f_gid), 1);
    check("fix_addr1", fm_addr, 32'h204);
    @(posedge clk); #1;
    f_valid = '0;

    // Round-robin, all ports requesting, zero-wait slave
    r_valid = 3'b111;
    for (int i = 0; i < 6; i++) begin
      rpush(i % 3, raddr(i % 3) ^ 32'hDEAD_0000, 1'b0);
      @(negedge clk);
      check("rr_gid", 64'(r_gid), 64'(i % 3));
      check("rr_busy_zero_wait", 64'(r_busy), 0);
      @(posedge clk); #1;
    end
    r_valid = '0;

    // Three wait states on port 1; port 0 arrives mid-transaction
    waits = 3;
    r_valid = 3'b010;
    rpush(1, raddr(1) ^ 32'hDEAD_0000, 1'b0);
    for (int c = 0; c < 4; c++) begin
      if (c == 1) r_valid = 3'b011;
      @(negedge clk);
      check("wait_addr", m_addr, raddr(1));
      check("wait_gid", 64'(r_gid), 1);
      check("wait_ready", 64'(r_ready), (c == 3) ? 64'b010 : 64'b000);
      @(posedge clk); #1;
    end
    waits = 0;
    r_valid = 3'b001;
    rpush(0, raddr(0) ^ 32'hDEAD_0000, 1'b0);
    @(negedge clk);
    check("wait_next_gid", 64'(r_gid), 0);
    check("wait_next_addr", m_addr, raddr(0));
    @(posedge clk); #1;
    r_valid = '0;

    // Hung slave: error completion on the 8th cycle
    never = 1'b1;
    r_valid = 3'b100;
    rpush(2, 32'hFFFF_FFFF, 1'b1);
    for (int c = 0; c <= 8; c++) begin
      @(negedge clk);
      if (c < 8) begin
        check("to_mvalid", 64'(m_valid), 1);
        check("to_ready", 64'(r_ready), 0);
        check("to_busy", 64'(r_busy), (c != 0) ? 64'd1 : 64'd0);
      end else begin
        check("to_mvalid_drop", 64'(m_valid), 0);
        check("to_ready_fire", 64'(r_ready), 64'b100);
      end
      @(posedge clk); #1;
    end
    never = 1'b0;
    r_valid = '0;
    @(negedge clk);
    check("to_idle_mvalid", 64'(m_valid), 0);
    check("to_idle_busy", 64'(r_busy), 0);
    @(posedge clk); #1;

    // Write from port 2, then an instruction fetch from port 1
    r_addr[2*32 +: 32]  = 32'h0000_0100;
    r_wdata[2*32 +: 32] = 32'hA5A5_5A5A;
    r_wstrb[2*4 +: 4]   = 4'b0110;
    r_instr = 3'b001;
    r_valid = 3'b100;
    rpush(2, 32'h0000_0100 ^ 32'hDEAD_0000, 1'b0);
    @(negedge clk);
    check("wr_mvalid", 64'(m_valid), 1);
    check("wr_addr", m_addr, 32'h0000_0100);
    check("wr_wdata", m_wdata, 32'hA5A5_5A5A);
    check("wr_wstrb", 64'(m_wstrb), 64'b0110);
    check("wr_instr", 64'(m_instr), 0);
    check("wr_gid", 64'(r_gid), 2);
    @(posedge clk); #1;
    r_valid = 3'b010;
    r_instr = 3'b010;
    rpush(1, raddr(1) ^ 32'hDEAD_0000, 1'b0);
    @(negedge clk);
    check("rd_instr", 64'(m_instr), 1);
    check("rd_wstrb", 64'(m_wstrb), 0);
    check("rd_addr", m_addr, raddr(1));
    @(posedge clk); #1;
    r_valid = '0;
    r_instr = '0;

    // Reset while BUSY on port 1: abandoned, then port 0 first
    waits = 3;
    r_valid = 3'b010;
    @(negedge clk);
    check("rb_gid", 64'(r_gid), 1);
    @(posedge clk); #1;
    @(negedge clk);
    check("rb_busy", 64'(r_busy), 1);
    @(posedge clk); #1;
    resetn = 1'b0;
    @(negedge clk);
    check("rb_rst_mvalid", 64'(m_valid), 0);
    check("rb_rst_ready", 64'(r_ready), 0);
    check("rb_rst_busy", 64'(r_busy), 0);
    @(posedge clk); #1;
    resetn = 1'b1;
    waits = 0;
    r_valid = 3'b111;
    rpush(0, raddr(0) ^ 32'hDEAD_0000, 1'b0);
    @(negedge clk);
    check("rb_post_busy", 64'(r_busy), 0);
    check("rb_post_gid", 64'(r_gid), 0);
    check("rb_post_addr", m_addr, raddr(0));
    @(posedge clk); #1;
    r_valid = '0;

    @(negedge clk);
    check("rr_sb_left", 64'(rq.size()), 0);
    check("fix_sb_left", 64'(fq.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
